// File: rtl/dm_lsu.sv
// Load/store unit between the RV32I execute stage and a data SRAM with configurable read latency.
// Accepts one access at a time over valid/ready, aligns stores, extracts/extends loads, and reports faults.
module dm_lsu #(
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_fault_o,
    output logic                  DM_OE,
    output logic [ADDR_WIDTH-1:0] DM_A,
    output logic [3:0]            DM_WEB,
    output logic [31:0]           DM_DI,
    input  logic [31:0]           DM_DO
);

    // Handshake: an access transfers in a cycle where req_valid_i && req_ready_o;
    // the core must hold all request fields stable until that cycle.
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [31:0]           di_q, di_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_fault_q, rsp_fault_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;

    logic                  accept;
    logic                  fault;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [31:0]           st_data;
    logic [3:0]            st_web;
    logic                  unused_addr;

    assign unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];
    assign word_addr   = req_addr_i[ADDR_WIDTH+1:2];
    assign req_ready_o = (state_q == IDLE) && !rst;
    assign accept      = req_valid_i && req_ready_o;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'd0:    extract = {{24{b[7]}}, b};
            3'd1:    extract = {{16{h[15]}}, h};
            3'd4:    extract = {24'd0, b};
            3'd5:    extract = {16'd0, h};
            default: extract = d;
        endcase
    endfunction

    always_comb begin
        fault = 1'b0;
        if (req_we_i) begin
            case (req_funct3_i)
                3'd0:    fault = 1'b0;
                3'd1:    fault = req_addr_i[0];
                3'd2:    fault = |req_addr_i[1:0];
                default: fault = 1'b1;
            endcase
        end else begin
            case (req_funct3_i)
                3'd0, 3'd4: fault = 1'b0;
                3'd1, 3'd5: fault = req_addr_i[0];
                3'd2:       fault = |req_addr_i[1:0];
                default:    fault = 1'b1;
            endcase
        end
    end

    // Store data is replicated across lanes so the SRAM only needs the byte enables.
    always_comb begin
        st_data = req_wdata_i;
        st_web  = 4'b0000;
        case (req_funct3_i[1:0])
            2'd0: begin
                st_data = {4{req_wdata_i[7:0]}};
                st_web  = ~(4'b0001 << req_addr_i[1:0]);
            end
            2'd1: begin
                st_data = {2{req_wdata_i[15:0]}};
                st_web  = req_addr_i[1] ? 4'b0011 : 4'b1100;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        di_d        = di_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = 32'd0;
        DM_OE       = 1'b0;
        DM_WEB      = 4'b1111;
        DM_A        = a_q;
        DM_DI       = di_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_valid_d = 1'b0;
                    if (fault) begin
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else if (req_we_i) begin
                        DM_A        = word_addr;
                        DM_DI       = st_data;
                        DM_WEB      = st_web;
                        a_d         = word_addr;
                        di_d        = st_data;
                        rsp_valid_d = 1'b1;
                    end else begin
                        DM_OE = 1'b1;
                        DM_A  = word_addr;
                        a_d   = word_addr;
                        f3_d  = req_funct3_i;
                        off_d = req_addr_i[1:0];
                        if (RD_LAT == 0) begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = extract(req_funct3_i, req_addr_i[1:0], DM_DO);
                        end else begin
                            state_d = WAIT;
                            cnt_d   = 4'(RD_LAT);
                        end
                    end
                end
            end
            WAIT: begin
                // Counter reaches 1 in the cycle the SRAM data is valid.
                DM_OE = 1'b1;
                if (cnt_q == 4'd1) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = extract(f3_q, off_q, DM_DO);
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            a_q         <= '0;
            di_q        <= 32'd0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            di_q        <= di_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_fault_o = rsp_fault_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: three instances (read latency 0, 2, 3) exercised one at a time, checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_dm_lsu;
  localparam int AW = 14;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  int          cur;
  logic        do_force;
  logic [31:0] do_force_val;
  logic        mem_mode;
  logic [31:0] do_rand;
  logic [31:0] dm_do_w;

  logic          vld       [3];
  logic          ready     [3];
  logic          rsp_valid [3];
  logic [31:0]   rsp_rdata [3];
  logic          rsp_fault [3];
  logic          dm_oe     [3];
  logic [AW-1:0] dm_a      [3];
  logic [3:0]    dm_web    [3];
  logic [31:0]   dm_di     [3];

  // Memory mode returns a word tagged with its word address, presented in the request cycle.
  assign dm_do_w = do_force ? do_force_val :
                   mem_mode ? {16'hC0DE, 2'b00, req_addr[15:2]} : do_rand;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    assign vld[g] = req_valid && (cur == g);
    dm_lsu #(.ADDR_WIDTH(AW), .RD_LAT(LAT)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (vld[g]),
      .req_ready_o  (ready[g]),
      .req_we_i     (req_we),
      .req_funct3_i (req_f3),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .rsp_valid_o  (rsp_valid[g]),
      .rsp_rdata_o  (rsp_rdata[g]),
      .rsp_fault_o  (rsp_fault[g]),
      .DM_OE        (dm_oe[g]),
      .DM_A         (dm_a[g]),
      .DM_WEB       (dm_web[g]),
      .DM_DI        (dm_di[g]),
      .DM_DO        (dm_do_w)
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d, inst %0d)", name, act, exp, cyc, cur);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  function automatic bit is_legal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = 1 << f3[1:0];
    if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    return (addr % sz) == 0;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    int     sz;
    longint v;
    sz = 1 << f3[1:0];
    if (sz == 4) return word;
    v = longint'(word >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
    if (!f3[2] && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return 32'(v);
  endfunction

  typedef struct {
    int          due;
    int          sample;
    bit          fault;
    bit          is_load;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
  } resp_t;

  resp_t         exp_q[$];
  int            busy_until = 0;
  logic [AW-1:0] last_a  = '0;
  logic [31:0]   last_di = 32'd0;
  int            log_cyc[$];
  logic [31:0]   log_dat[$];

  always @(negedge clk) begin
    int            c, sz;
    bit            exp_rdy, acc;
    resp_t         r;
    logic          oe_e;
    logic [3:0]    web_e;
    logic [AW-1:0] a_e, wa;
    logic [31:0]   di_e;
    cyc++;
    c       = cur;
    exp_rdy = !rst && (cyc >= busy_until);
    acc     = req_valid && exp_rdy;
    chk("req_ready", 32'(ready[c]), 32'(exp_rdy));
    if (rst) begin
      chk("web_in_reset", 32'(dm_web[c]), 32'hF);
      exp_q.delete();
      busy_until = 0;
      last_a     = '0;
      last_di    = 32'd0;
    end else begin
      if (rsp_valid[c]) begin
        log_cyc.push_back(cyc);
        log_dat.push_back(rsp_rdata[c]);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid[c]), 32'd1);
        chk("rsp_fault", 32'(rsp_fault[c]), 32'(r.fault));
        chk("rsp_rdata", rsp_rdata[c], r.rdata);
      end else begin
        chk("rsp_valid_idle", 32'(rsp_valid[c]), 32'd0);
      end
      wa    = AW'(req_addr >> 2);
      oe_e  = 1'b0;
      web_e = 4'hF;
      a_e   = last_a;
      di_e  = last_di;
      r     = '{due: 0, sample: -1, fault: 0, is_load: 0, f3: req_f3, off: req_addr[1:0], rdata: 0};
      if (cyc < busy_until) begin
        oe_e = 1'b1;
      end else if (acc) begin
        if (!is_legal(req_we, req_f3, req_addr)) begin
          r.fault = 1;
          r.due   = cyc + 1;
        end else if (req_we) begin
          sz = 1 << req_f3[1:0];
          for (int i = 0; i < 4; i++) begin
            di_e[8*i +: 8] = req_wdata[8*(i % sz) +: 8];
            if (i >= int'(req_addr[1:0]) && i < int'(req_addr[1:0]) + sz) web_e[i] = 1'b0;
          end
          a_e     = wa;
          last_a  = wa;
          last_di = di_e;
          r.due   = cyc + 1;
        end else begin
          oe_e     = 1'b1;
          a_e      = wa;
          last_a   = wa;
          r.is_load = 1;
          r.sample = cyc + lat_of(c);
          r.due    = cyc + lat_of(c) + 1;
        end
        busy_until = r.due;
        exp_q.push_back(r);
      end
      chk("dm_oe", 32'(dm_oe[c]), 32'(oe_e));
      chk("dm_web", 32'(dm_web[c]), 32'(web_e));
      chk("dm_a", 32'(dm_a[c]), 32'(a_e));
      chk("dm_di", dm_di[c], di_e);
      foreach (exp_q[i])
        if (exp_q[i].is_load && exp_q[i].sample == cyc)
          exp_q[i].rdata = load_value(exp_q[i].f3, exp_q[i].off, dm_do_w);
    end
  end

  // ---------------- driver ----------------
  logic        acc_oe;
  logic [3:0]  acc_web;
  logic [31:0] acc_a, acc_di;
  int          acc_waits;

  initial forever begin
    @(posedge clk);
    #1;
    do_rand = $urandom;
  end

  task automatic do_reset(input int k);
    rst       = 1'b1;
    req_valid = 1'b0;
    cur       = k;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_f3    = f3;
    req_addr  = addr;
    req_wdata = wdata;
    acc_waits = 0;
    @(negedge clk);
    while (!ready[cur] && acc_waits < 50) begin
      acc_waits++;
      @(negedge clk);
    end
    if (!ready[cur]) chk("accept_timeout", 32'd0, 32'd1);
    acc_oe  = dm_oe[cur];
    acc_web = dm_web[cur];
    acc_a   = 32'(dm_a[cur]);
    acc_di  = dm_di[cur];
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output logic [31:0] d, output logic f);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[cur] && lat < 40);
    if (!rsp_valid[cur]) chk("rsp_timeout", 32'd0, 32'd1);
    d = rsp_rdata[cur];
    f = rsp_fault[cur];
    @(posedge clk);
    #1;
  endtask

  task automatic check_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] dov, input logic [31:0] exp);
    int          lat;
    logic [31:0] d;
    logic        f;
    do_force     = 1'b1;
    do_force_val = dov;
    send(1'b0, f3, addr, 32'd0);
    chk({name, "_oe"}, 32'(acc_oe), 32'd1);
    wait_rsp(lat, d, f);
    chk({name, "_latency"}, 32'(lat), 32'd3);
    chk({name, "_data"}, d, exp);
    chk({name, "_fault"}, 32'(f), 32'd0);
    do_force = 1'b0;
  endtask

  initial begin
    int          lat, sz, tmp;
    logic [31:0] d, a;
    logic        f;
    logic [2:0]  f3;
    bit          we;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; cur = 1; do_force = 1'b0; do_force_val = 32'd0; mem_mode = 1'b0;
    do_rand = 32'd0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready[1]), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("reset_dm_web", 32'(dm_web[1]), 32'hF);
    chk("reset_dm_a", 32'(dm_a[1]), 32'd0);
    @(posedge clk);
    #1;

    // Directed: latency-2 instance.
    send(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    chk("sw_dm_a", acc_a, 32'd4);
    chk("sw_dm_web", 32'(acc_web), 32'h0);
    chk("sw_dm_di", acc_di, 32'hDEADBEEF);
    wait_rsp(lat, d, f);
    chk("sw_latency", 32'(lat), 32'd1);
    chk("sw_fault", 32'(f), 32'd0);
    send(1'b1, 3'd0, 32'h13, 32'h000000A5);
    chk("sb_dm_web", 32'(acc_web), 32'h7);
    chk("sb_dm_di", acc_di, 32'hA5A5A5A5);
    wait_rsp(lat, d, f);
    check_load("lb", 3'd0, 32'h13, 32'hA5000000, 32'hFFFFFFA5);
    check_load("lbu", 3'd4, 32'h13, 32'hA5000000, 32'h000000A5);
    check_load("lh_hi", 3'd1, 32'h22, 32'h80017FFF, 32'hFFFF8001);
    check_load("lhu_hi", 3'd5, 32'h22, 32'h80017FFF, 32'h00008001);
    check_load("lh_lo", 3'd1, 32'h20, 32'h80017FFF, 32'h00007FFF);
    for (int i = 0; i < 2; i++) begin
      send(1'b0, (i == 0) ? 3'd2 : 3'd3, (i == 0) ? 32'h5 : 32'h0, 32'd0);
      chk("fault_dm_oe", 32'(acc_oe), 32'd0);
      chk("fault_dm_web", 32'(acc_web), 32'hF);
      wait_rsp(lat, d, f);
      chk("fault_latency", 32'(lat), 32'd1);
      chk("fault_flag", 32'(f), 32'd1);
      chk("fault_rdata", d, 32'd0);
    end

    // Directed: latency-0 back-to-back loads.
    do_reset(0);
    mem_mode = 1'b1;
    log_cyc.delete();
    log_dat.delete();
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 3'd2, 32'(4 * i), 32'd0);
      chk("b2b_no_stall", 32'(acc_waits), 32'd0);
    end
    repeat (3) begin @(posedge clk); #1; end
    mem_mode = 1'b0;
    chk("b2b_rsp_count", 32'(log_cyc.size()), 32'd3);
    if (log_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("b2b_rdata", log_dat[i], 32'hC0DE0000 + 32'(i));
      chk("b2b_consecutive", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
    end

    // Directed: reset while a latency-3 load waits.
    do_reset(2);
    log_cyc.delete();
    log_dat.delete();
    send(1'b0, 3'd2, 32'h40, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_dm_oe", 32'(dm_oe[2]), 32'd0);
    chk("rst_wait_ready", 32'(ready[2]), 32'd1);
    repeat (6) begin @(posedge clk); #1; end
    chk("rst_wait_no_rsp", 32'(log_cyc.size()), 32'd0);

    // Random traffic on every instance, with occasional resets.
    for (int k = 0; k < 3; k++) begin
      do_reset(k);
      repeat (150) begin
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 8) begin
          tmp = $urandom_range(0, we ? 2 : 4);
          f3  = 3'((tmp < 3) ? tmp : tmp + 1);
        end else begin
          f3 = 3'($urandom_range(0, 7));
        end
        sz = 1 << f3[1:0];
        a  = $urandom;
        if ($urandom_range(0, 9) < 8) a = a & ~(32'(sz) - 32'd1);
        send(we, f3, a, $urandom);
        if ($urandom_range(0, 24) == 0) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst = 1'b0;
        end
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      repeat (5) begin @(posedge clk); #1; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
